// File: rtl/sh7604_bsc.sv
// sh7604_bsc: bus state controller behind the SH7604 DMAC.
// Turns DBUS requests into external CS0..CS3 cycles with programmable waits and 4-beat bursts.
// Optional build macro: BSC_EXT_WAIT_EN (WAIT_N low stretches the final wait state).
module sh7604_bsc #(
    parameter int unsigned ADDR_W   = 27,
    parameter logic [15:0] WCR_INIT = 16'h00FF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE_R,
    input  logic              CE_F,

    input  logic [31:0]       DBUS_A,
    input  logic [31:0]       DBUS_DI,
    output logic [31:0]       DBUS_DO,
    input  logic [3:0]        DBUS_BA,
    input  logic              DBUS_WE,
    input  logic              DBUS_REQ,
    input  logic              DBUS_BURST,
    input  logic              DBUS_LOCK,
    output logic              DBUS_WAIT,
    output logic              BSC_ACK,

    input  logic [31:0]       IBUS_A,
    input  logic [31:0]       IBUS_DI,
    input  logic              IBUS_WE,
    input  logic              IBUS_REQ,
    output logic [31:0]       IBUS_DO,
    output logic              IBUS_ACT,

    output logic [ADDR_W-1:0] A,
    input  logic [31:0]       DI,
    output logic [31:0]       DO,
    output logic [3:0]        CS_N,
    output logic              RD_N,
    output logic [3:0]        WE_N,
    input  logic              WAIT_N
);

    typedef enum logic [1:0] {StIdle, StT1, StTw, StT2} state_e;

    localparam logic [31:0] WcrAddr = 32'hFFFF_FFE8;
    localparam logic [15:0] WcrKey  = 16'hA55A;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   a_q, a_d;
    logic [31:0]         do_q, do_d;
    logic [31:0]         dbus_do_q, dbus_do_d;
    logic [1:0]          wcnt_q, wcnt_d;
    logic [1:0]          beat_q, beat_d;
    logic [3:0]          cs_n_q, cs_n_d;
    logic                rd_n_q, rd_n_d;
    logic [3:0]          we_n_q, we_n_d;
    logic                ack_q, ack_d;
    logic [15:0]         wcr_q;
    logic [31:0]         ibus_do_q;

    logic                ext;
    logic [1:0]          req_area;
    logic [1:0]          req_wcnt;
    logic                start;
    logic                cap_rd;
    logic                tw_release;
    logic                reg_hit;
    logic                unused_bits;

    // Upper address bits beyond ADDR_W only take part in decode.
    assign unused_bits = ^{DBUS_A, WAIT_N};

    assign ext      = DBUS_A[31:29] != 3'b111;
    assign req_area = DBUS_A[26:25];
    assign reg_hit  = IBUS_REQ && (IBUS_A == WcrAddr);

`ifdef BSC_EXT_WAIT_EN
    assign tw_release = WAIT_N;
`else
    assign tw_release = 1'b1;
`endif

    // Wait count of the area addressed by the incoming request.
    always_comb begin
        req_wcnt = 2'd0;
        unique case (req_area)
            2'd0: req_wcnt = wcr_q[1:0];
            2'd1: req_wcnt = wcr_q[3:2];
            2'd2: req_wcnt = wcr_q[5:4];
            2'd3: req_wcnt = wcr_q[7:6];
        endcase
    end

    // Next-state, latched request fields and next strobe values.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        do_d      = do_q;
        dbus_do_d = dbus_do_q;
        wcnt_d    = wcnt_q;
        beat_d    = beat_q;
        cs_n_d    = cs_n_q;
        rd_n_d    = rd_n_q;
        we_n_d    = we_n_q;
        ack_d     = ack_q;
        start     = 1'b0;
        cap_rd    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (DBUS_REQ && ext) begin
                    start = 1'b1;
                end
            end
            StT1: begin
                if (wcnt_q != 2'd0) begin
                    state_d = StTw;
                end else begin
                    state_d = StT2;
                    cap_rd  = 1'b1;
                end
            end
            StTw: begin
                if (wcnt_q > 2'd1) begin
                    wcnt_d = wcnt_q - 2'd1;
                end else if (tw_release) begin
                    wcnt_d  = 2'd0;
                    state_d = StT2;
                    cap_rd  = 1'b1;
                end
            end
            StT2: begin
                if (DBUS_BURST && (beat_q != 2'd3)) begin
                    // Single-cycle follow-on beat; strobes stay asserted.
                    beat_d = beat_q + 2'd1;
                    a_d    = DBUS_A[ADDR_W-1:0];
                    do_d   = DBUS_DI;
                    cap_rd = 1'b1;
                end else if (DBUS_LOCK && DBUS_REQ && ext) begin
                    start = 1'b1;
                end else begin
                    state_d = StIdle;
                    cs_n_d  = 4'hF;
                    rd_n_d  = 1'b1;
                    we_n_d  = 4'hF;
                    ack_d   = 1'b0;
                end
            end
        endcase

        if (start) begin
            state_d = StT1;
            a_d     = DBUS_A[ADDR_W-1:0];
            do_d    = DBUS_DI;
            wcnt_d  = req_wcnt;
            beat_d  = 2'd0;
            cs_n_d  = ~(4'b0001 << req_area);
            rd_n_d  = DBUS_WE;
            we_n_d  = DBUS_WE ? ~DBUS_BA : 4'hF;
            ack_d   = 1'b1;
        end

        if (cap_rd) begin
            dbus_do_d = DI;
        end
    end

    // FSM state and registered bus outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            a_q       <= '0;
            do_q      <= 32'h0;
            dbus_do_q <= 32'h0;
            wcnt_q    <= 2'd0;
            beat_q    <= 2'd0;
            cs_n_q    <= 4'hF;
            rd_n_q    <= 1'b1;
            we_n_q    <= 4'hF;
            ack_q     <= 1'b0;
        end else if (CE_R) begin
            state_q   <= state_d;
            a_q       <= a_d;
            do_q      <= do_d;
            dbus_do_q <= dbus_do_d;
            wcnt_q    <= wcnt_d;
            beat_q    <= beat_d;
            cs_n_q    <= cs_n_d;
            rd_n_q    <= rd_n_d;
            we_n_q    <= we_n_d;
            ack_q     <= ack_d;
        end
    end

    // WCR write, accepted only with the unlock key in the upper half.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wcr_q <= WCR_INIT;
        end else if (CE_R && reg_hit && IBUS_WE && (IBUS_DI[31:16] == WcrKey)) begin
            wcr_q <= IBUS_DI[15:0];
        end
    end

    // Register read data latched on the falling-phase enable.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ibus_do_q <= 32'h0;
        end else if (CE_F) begin
            ibus_do_q <= reg_hit ? {16'h0000, wcr_q} : 32'h0;
        end
    end

    assign DBUS_WAIT = DBUS_REQ && ext && (state_q != StT2);
    assign DBUS_DO   = dbus_do_q;
    assign BSC_ACK   = ack_q;
    assign IBUS_DO   = ibus_do_q;
    assign IBUS_ACT  = reg_hit;
    assign A         = a_q;
    assign DO        = do_q;
    assign CS_N      = cs_n_q;
    assign RD_N      = rd_n_q;
    assign WE_N      = we_n_q;

endmodule

// File: tb/tb_sh7604_bsc.sv
// tb_sh7604_bsc: directed scoreboard bench for sh7604_bsc.
module tb_sh7604_bsc;

    localparam int unsigned AW = 27;

    logic          CLK, RST, CE_R, CE_F;
    logic [31:0]   DBUS_A, DBUS_DI, DBUS_DO;
    logic [3:0]    DBUS_BA;
    logic          DBUS_WE, DBUS_REQ, DBUS_BURST, DBUS_LOCK, DBUS_WAIT, BSC_ACK;
    logic [31:0]   IBUS_A, IBUS_DI, IBUS_DO;
    logic          IBUS_WE, IBUS_REQ, IBUS_ACT;
    logic [AW-1:0] A;
    logic [31:0]   DI, DO;
    logic [3:0]    CS_N, WE_N;
    logic          RD_N, WAIT_N;

    sh7604_bsc #(.ADDR_W(AW), .WCR_INIT(16'h00FF)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F),
        .DBUS_A(DBUS_A), .DBUS_DI(DBUS_DI), .DBUS_DO(DBUS_DO), .DBUS_BA(DBUS_BA),
        .DBUS_WE(DBUS_WE), .DBUS_REQ(DBUS_REQ), .DBUS_BURST(DBUS_BURST),
        .DBUS_LOCK(DBUS_LOCK), .DBUS_WAIT(DBUS_WAIT), .BSC_ACK(BSC_ACK),
        .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_WE(IBUS_WE), .IBUS_REQ(IBUS_REQ),
        .IBUS_DO(IBUS_DO), .IBUS_ACT(IBUS_ACT),
        .A(A), .DI(DI), .DO(DO), .CS_N(CS_N), .RD_N(RD_N), .WE_N(WE_N), .WAIT_N(WAIT_N)
    );

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] rd;
        logic        chk_rd;
        logic [3:0]  cs_n;
        logic        rd_n;
        logic [3:0]  we_n;
        logic [26:0] a;
        logic [31:0] wdo;
        logic [7:0]  per;
    } beat_t;

    typedef struct packed {
        logic        wt;
        logic        zeros;
        logic        act;
        logic [31:0] ibus_do;
    } snap_t;

    beat_t       beat_exp_q[$];
    snap_t       snap_exp_q[$];
    logic [31:0] reg_exp_q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cs_cnt = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    initial begin : monitor
        beat_t       b;
        snap_t       s;
        logic [31:0] r;
        forever begin
            @(negedge CLK);
            if (CS_N != 4'hF) cs_cnt++;
            else cs_cnt = 0;
            if (snap_exp_q.size() != 0) begin
                s = snap_exp_q.pop_front();
                chk("snap_cs_n", 64'(CS_N), 64'(4'hF));
                chk("snap_rd_n", 64'(RD_N), 64'(1'b1));
                chk("snap_we_n", 64'(WE_N), 64'(4'hF));
                chk("snap_ack", 64'(BSC_ACK), 64'(1'b0));
                chk("snap_wait", 64'(DBUS_WAIT), 64'(s.wt));
                chk("snap_ibus_act", 64'(IBUS_ACT), 64'(s.act));
                chk("snap_ibus_do", 64'(IBUS_DO), 64'(s.ibus_do));
                if (s.zeros) begin
                    chk("snap_a_zero", 64'(A), 64'(0));
                    chk("snap_do_zero", 64'(DO), 64'(0));
                    chk("snap_dbus_do_zero", 64'(DBUS_DO), 64'(0));
                end
            end
            if (DBUS_REQ && (DBUS_A[31:29] != 3'b111) && !DBUS_WAIT) begin
                if (beat_exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL beat_unexpected: got beat at A=0x%0h, expected none", A);
                end else begin
                    b = beat_exp_q.pop_front();
                    chk($sformatf("beat%0d_cs_n", b.id), 64'(CS_N), 64'(b.cs_n));
                    chk($sformatf("beat%0d_rd_n", b.id), 64'(RD_N), 64'(b.rd_n));
                    chk($sformatf("beat%0d_we_n", b.id), 64'(WE_N), 64'(b.we_n));
                    chk($sformatf("beat%0d_ack", b.id), 64'(BSC_ACK), 64'(1'b1));
                    chk($sformatf("beat%0d_a", b.id), 64'(A), 64'(b.a));
                    chk($sformatf("beat%0d_do", b.id), 64'(DO), 64'(b.wdo));
                    chk($sformatf("beat%0d_period", b.id), 64'(cs_cnt), 64'(b.per));
                    if (b.chk_rd) chk($sformatf("beat%0d_rdata", b.id), 64'(DBUS_DO), 64'(b.rd));
                end
            end
            if (IBUS_REQ && !IBUS_WE && IBUS_ACT) begin
                if (reg_exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL reg_unexpected: got read 0x%0h, expected none", IBUS_DO);
                end else begin
                    r = reg_exp_q.pop_front();
                    chk("wcr_read", 64'(IBUS_DO), 64'(r));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(negedge CLK); #1; end
    endtask

    task automatic drv(input logic [31:0] a, input logic we, input logic [3:0] ba,
                       input logic [31:0] wd, input logic [31:0] di, input logic burst,
                       input logic lock);
        DBUS_A = a; DBUS_WE = we; DBUS_BA = ba; DBUS_DI = wd; DI = di;
        DBUS_BURST = burst; DBUS_LOCK = lock; DBUS_REQ = 1'b1;
    endtask

    task automatic rel();
        DBUS_REQ = 1'b0; DBUS_BURST = 1'b0; DBUS_LOCK = 1'b0;
    endtask

    task automatic wait_acc(input string nm);
        int  n = 0;
        bit  done = 0;
        while (!done && n < 20) begin
            @(negedge CLK); #1;
            n++;
            if (!DBUS_WAIT) done = 1;
        end
        if (!done) begin
            n_chk++;
            $display("FAIL %s: got DBUS_WAIT stuck high for 20 cycles, expected release", nm);
        end
    endtask

    task automatic exp_beat(input logic [7:0] id, input logic [31:0] rd, input logic chk_rd,
                            input logic [3:0] cs_n, input logic rd_n, input logic [3:0] we_n,
                            input logic [31:0] addr, input logic [31:0] wdo,
                            input logic [7:0] per);
        beat_t b;
        b.id = id; b.rd = rd; b.chk_rd = chk_rd; b.cs_n = cs_n; b.rd_n = rd_n;
        b.we_n = we_n; b.a = addr[26:0]; b.wdo = wdo; b.per = per;
        beat_exp_q.push_back(b);
    endtask

    task automatic push_snap(input logic wt, input logic zeros, input logic act,
                             input logic [31:0] ibus_do);
        snap_t s;
        s.wt = wt; s.zeros = zeros; s.act = act; s.ibus_do = ibus_do;
        snap_exp_q.push_back(s);
    endtask

    task automatic reg_rd(input logic [31:0] exp);
        IBUS_A = 32'hFFFF_FFE8; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
        reg_exp_q.push_back(exp);
        idle(1);
        IBUS_REQ = 1'b0;
    endtask

    task automatic reg_wr(input logic [31:0] d);
        IBUS_A = 32'hFFFF_FFE8; IBUS_WE = 1'b1; IBUS_DI = d; IBUS_REQ = 1'b1;
        idle(1);
        IBUS_REQ = 1'b0; IBUS_WE = 1'b0;
    endtask

    // Stimulus: directed transactions with hand-computed expectations.
    initial begin : stim
        logic [7:0] ewait_per;
        CE_R = 1'b1; CE_F = 1'b1; RST = 1'b1; WAIT_N = 1'b1;
        DBUS_A = 32'h0; DBUS_DI = 32'h0; DBUS_BA = 4'hF; DBUS_WE = 1'b0;
        DBUS_REQ = 1'b0; DBUS_BURST = 1'b0; DBUS_LOCK = 1'b0; DI = 32'h0;
        IBUS_A = 32'h0; IBUS_DI = 32'h0; IBUS_WE = 1'b0; IBUS_REQ = 1'b0;
        push_snap(1'b0, 1'b1, 1'b0, 32'h0);
        idle(2);
        RST = 1'b0;

        // Reset WCR value, then a miss right after a hit must read 0.
        reg_rd(32'h0000_00FF);
        IBUS_A = 32'hFFFF_FFE4; IBUS_WE = 1'b0; IBUS_REQ = 1'b1;
        push_snap(1'b0, 1'b1, 1'b0, 32'h0);
        idle(1);
        IBUS_REQ = 1'b0;

        // Area 0 read with 3 reset waits: T1, TW x3, T2.
        drv(32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'hCAFE_0001, 1'b0, 1'b0);
        exp_beat(8'd1, 32'hCAFE_0001, 1'b1, 4'hE, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 8'd5);
        wait_acc("rd_w3");
        rel(); idle(2);

        // WCR key protection.
        reg_wr(32'h1234_0000);
        reg_rd(32'h0000_00FF);
        reg_wr(32'hA55A_0000);
        reg_rd(32'h0000_0000);

        // Area 0 read with zero waits: T1, T2.
        drv(32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h1234_5678, 1'b0, 1'b0);
        exp_beat(8'd2, 32'h1234_5678, 1'b1, 4'hE, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 8'd2);
        wait_acc("rd_w0");
        rel(); idle(2);

        // Waits: area0=0, area1=1, area2=2, area3=1.
        reg_wr(32'hA55A_0064);
        reg_rd(32'h0000_0064);

        // Area 2 byte write, 2 waits: T1, TW, TW, T2.
        drv(32'h0400_0002, 1'b1, 4'b0011, 32'hAABB_CCDD, 32'h0, 1'b0, 1'b0);
        exp_beat(8'd3, 32'h0, 1'b0, 4'hB, 1'b1, 4'b1100, 32'h0400_0002, 32'hAABB_CCDD, 8'd4);
        wait_acc("wr_w2");
        rel();
        push_snap(1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);

        // Area 1 burst read, 1 wait: beats at periods 3..6.
        drv(32'h0200_0010, 1'b0, 4'hF, 32'h0, 32'h1111_1111, 1'b1, 1'b0);
        exp_beat(8'd4, 32'h1111_1111, 1'b1, 4'hD, 1'b0, 4'hF, 32'h0200_0010, 32'h0, 8'd3);
        wait_acc("burst0");
        drv(32'h0200_0014, 1'b0, 4'hF, 32'h1, 32'h2222_2222, 1'b1, 1'b0);
        exp_beat(8'd5, 32'h2222_2222, 1'b1, 4'hD, 1'b0, 4'hF, 32'h0200_0014, 32'h1, 8'd4);
        wait_acc("burst1");
        drv(32'h0200_0018, 1'b0, 4'hF, 32'h2, 32'h3333_3333, 1'b1, 1'b0);
        exp_beat(8'd6, 32'h3333_3333, 1'b1, 4'hD, 1'b0, 4'hF, 32'h0200_0018, 32'h2, 8'd5);
        wait_acc("burst2");
        drv(32'h0200_001C, 1'b0, 4'hF, 32'h3, 32'h4444_4444, 1'b1, 1'b0);
        exp_beat(8'd7, 32'h4444_4444, 1'b1, 4'hD, 1'b0, 4'hF, 32'h0200_001C, 32'h3, 8'd6);
        wait_acc("burst3");
        rel();
        push_snap(1'b0, 1'b0, 1'b0, 32'h0);
        idle(2);

        // Locked back-to-back reads on area 0: second T1 follows T2 directly.
        drv(32'h0000_0200, 1'b0, 4'hF, 32'h0, 32'h5555_AAAA, 1'b0, 1'b1);
        exp_beat(8'd8, 32'h5555_AAAA, 1'b1, 4'hE, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 8'd2);
        wait_acc("lock0");
        drv(32'h0000_0300, 1'b0, 4'hF, 32'h0, 32'hA5A5_A5A5, 1'b0, 1'b1);
        exp_beat(8'd9, 32'hA5A5_A5A5, 1'b1, 4'hE, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 8'd4);
        wait_acc("lock1");
        rel(); idle(2);

        // Area 3 read, 1 wait, WAIT_N low for three TW cycles.
`ifdef BSC_EXT_WAIT_EN
        ewait_per = 8'd6;
`else
        ewait_per = 8'd3;
`endif
        drv(32'h0600_0000, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0);
        exp_beat(8'd10, 32'h0BAD_F00D, 1'b1, 4'h7, 1'b0, 4'hF, 32'h0600_0000, 32'h0,
                 ewait_per);
        fork
            wait_acc("ext_wait");
            begin
                idle(2);
                WAIT_N = 1'b0;
                idle(3);
                WAIT_N = 1'b1;
            end
        join
        rel(); idle(2);

        // Internal-space request is ignored: no wait, no strobes.
        drv(32'hE000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, 1'b0);
        push_snap(1'b0, 1'b0, 1'b0, 32'h0);
        idle(1);
        rel(); idle(1);

        // Reset while in TW of an area 2 write.
        drv(32'h0400_0010, 1'b1, 4'hF, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
        idle(2);
        RST = 1'b1;
        push_snap(1'b1, 1'b1, 1'b0, 32'h0);
        idle(1);
        DBUS_REQ = 1'b0;
        push_snap(1'b0, 1'b1, 1'b0, 32'h0);
        idle(1);
        RST = 1'b0;
        reg_rd(32'h0000_00FF);
        idle(3);

        chk("beats_pending", 64'(beat_exp_q.size()), 64'(0));
        chk("reg_reads_pending", 64'(reg_exp_q.size()), 64'(0));
        chk("snaps_pending", 64'(snap_exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
